inst_fetch: RTL and testbench

- Upstream neighbour of the main control decoder. Owns the program counter and the instruction register, and fetches each instruction from instruction memory over a req/ready handshake.
- Holds the fetched instruction stable on inst_out while the decoder registers its control outputs.
- Computes the next PC from the decoder's branch/jump outputs and the ALU zero flag, giving a multi-cycle FETCH -> DECODE -> EXEC sequence per instruction.

---
 rtl/fetch_pkg.sv | 36 +++
 rtl/next_pc_calc.sv | 43 ++++
 rtl/inst_fetch.sv | 133 +++++++++++++
 tb/tb_inst_fetch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: FSM state encodings,
// the default reset PC, the NOP word and the instruction field positions
// that the next-PC logic relies on (independent of opcode).
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_EXEC   = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    // Instruction field positions.
    localparam int IMM16_MSB = 15;
    localparam int IMM16_LSB = 0;
    localparam int JIDX_MSB  = 25;
    localparam int JIDX_LSB  = 0;

    // Word-scaled, sign-extended branch displacement taken from IMM16.
    function automatic logic [31:0] branch_offset(input logic [31:0] inst);
        return {{14{inst[IMM16_MSB]}}, inst[IMM16_MSB:IMM16_LSB], 2'b00};
    endfunction

    // Jump target: keep the upper nibble of the sequential PC, splice in JIDX.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] inst);
        return {pc_plus4[31:28], inst[JIDX_MSB:JIDX_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC selection.
// Priority: jump > (branch && zero) > sequential. All arithmetic is 32-bit
// modulo, so wrap-around past 0xFFFF_FFFC and negative offsets fall out of
// the plain adder.
//
// Ports:
//   pc_plus4  in  32  address of the following sequential instruction
//   inst_out  in  32  instruction currently held in the instruction register
//   branch    in   1  decoder branch control
//   jump      in   1  decoder jump control
//   zero      in   1  ALU zero flag
//   next_pc   out 32  PC to load when the current instruction retires
// ---------------------------------------------------------------------------
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] inst_out,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    // Opcode bits are not needed here; the decoder has already resolved them
    // into branch/jump.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^inst_out[31:26];

    always_comb begin
        // NOTE: assign a default before any branching so every path drives
        // next_pc; otherwise synthesis infers a latch.
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target(pc_plus4, inst_out);
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_offset(inst_out);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Owns the program counter and instruction register. Each instruction walks
// FETCH -> DECODE -> EXEC: FETCH requests the word at pc over a req/ready
// handshake, DECODE gives the registered decoder a cycle with a stable
// instruction, EXEC waits out any stall and then loads the next PC.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous active-high reset
//   imem_addr   out 32  instruction byte address (word aligned)
//   imem_req    out  1  fetch request, high only in FETCH
//   imem_rdata  in  32  instruction word, captured on imem_req && imem_ready
//   imem_ready  in   1  memory accepts request, rdata valid same cycle
//   stall       in   1  hold current instruction in EXEC
//   branch      in   1  decoder branch control
//   jump        in   1  decoder jump control
//   zero        in   1  ALU zero flag
//   inst_out    out 32  instruction register
//   inst_valid  out  1  high in DECODE and EXEC
//   pc_out      out 32  PC of the instruction in inst_out
//   pc_plus4    out 32  pc_out + 4
//   state_out   out  2  current FSM state encoding
// ---------------------------------------------------------------------------
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [1:0]  state_out
);

    fetch_state_t state;
    fetch_state_t next_state;
    logic [31:0]  pc;
    logic [31:0]  inst_reg;
    logic [31:0]  next_pc;
    logic         capture;
    logic         retire;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RESET;
        end else begin
            // NOTE: sequential state is written with non-blocking (<=) so all
            // flops update together from pre-edge values.
            state <= next_state;
        end
    end

    // ---------------- next state and outputs ----------------
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        case (state)
            S_RESET: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    capture    = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                inst_valid = 1'b1;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                inst_valid = 1'b1;
                if (!stall) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

    // ---------------- PC and instruction register ----------------
    // capture is only raised in FETCH, so rdata outside FETCH never reaches
    // the instruction register, and reset abandons any pending handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            inst_reg <= NOP;
        end else begin
            if (capture) begin
                inst_reg <= imem_rdata;
            end
            if (retire) begin
                pc <= next_pc;
            end
        end
    end

    next_pc_calc u_next_pc_calc (
        .pc_plus4 (pc_plus4),
        .inst_out (inst_reg),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    assign pc_plus4  = pc + 32'd4;
    assign pc_out    = pc;
    assign imem_addr = pc;
    assign inst_out  = inst_reg;
    assign state_out = state;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch. Walks a hand-built program: sequential
// fetches, taken/not-taken branches, jump-over-branch priority, upper-nibble
// jump region, wait states, stalls, 32-bit PC wrap and reset mid-fetch.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [1:0]  state_out;

    int total = 0;
    int bad   = 0;

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .stall      (stall),
        .branch     (branch),
        .jump       (jump),
        .zero       (zero),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction starting in FETCH at addr. waits = memory wait
    // cycles, stalls = extra EXEC cycles. Control inputs are applied in EXEC.
    task automatic do_inst(input string tag, input logic [31:0] addr, input logic [31:0] word,
                           input int waits, input logic br, input logic jp, input logic z,
                           input int stalls);
        int          extra;
        logic [31:0] prev_inst;
        extra = 0;
        while (state_out != 2'd1 && extra < 8) begin
            tick();
            extra++;
        end
        check({tag, ":fetch_lat"}, extra, 0);
        check({tag, ":f_state"}, {30'd0, state_out}, 32'd1);
        check({tag, ":f_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, ":f_addr"}, imem_addr, addr);
        check({tag, ":f_valid"}, {31'd0, inst_valid}, 32'd0);
        prev_inst = inst_out;
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            tick();
            check({tag, ":w_state"}, {30'd0, state_out}, 32'd1);
            check({tag, ":w_addr"}, imem_addr, addr);
            check({tag, ":w_inst"}, inst_out, prev_inst);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        tick();
        imem_ready = 1'b0;
        imem_rdata = ~word;
        check({tag, ":d_state"}, {30'd0, state_out}, 32'd2);
        check({tag, ":d_inst"}, inst_out, word);
        check({tag, ":d_valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, ":d_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, ":d_pc"}, pc_out, addr);
        check({tag, ":d_pc4"}, pc_plus4, addr + 32'd4);
        stall = 1'b1;
        tick();
        check({tag, ":e_state"}, {30'd0, state_out}, 32'd3);
        check({tag, ":e_inst"}, inst_out, word);
        check({tag, ":e_valid"}, {31'd0, inst_valid}, 32'd1);
        branch = br;
        jump   = jp;
        zero   = z;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            tick();
            check({tag, ":s_state"}, {30'd0, state_out}, 32'd3);
            check({tag, ":s_pc"}, pc_out, addr);
            check({tag, ":s_inst"}, inst_out, word);
        end
        stall = 1'b0;
        tick();
        branch = 1'b0;
        jump   = 1'b0;
        zero   = 1'b0;
        check({tag, ":x_state"}, {30'd0, state_out}, 32'd1);
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        check("rst_state", {30'd0, state_out}, 32'd0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_inst", inst_out, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_exit_state", {30'd0, state_out}, 32'd1);

        // Sequential, zero-wait.
        do_inst("seq0", 32'h0000_0000, 32'h8C01_0004, 0, 1'b0, 1'b0, 1'b0, 0);
        do_inst("seq1", 32'h0000_0004, 32'h0022_1820, 0, 1'b0, 1'b0, 1'b0, 0);
        do_inst("seq2", 32'h0000_0008, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 0);
        do_inst("seq3", 32'h0000_000C, 32'h0022_1820, 0, 1'b0, 1'b0, 1'b0, 0);
        // BEQ at 0x10, offset -2 words: taken -> 0x0C.
        do_inst("beq_t", 32'h0000_0010, 32'h1000_FFFE, 0, 1'b1, 1'b0, 1'b1, 0);
        do_inst("seq4", 32'h0000_000C, 32'h0022_1820, 0, 1'b0, 1'b0, 1'b0, 0);
        // Not taken -> 0x14.
        do_inst("beq_nt", 32'h0000_0010, 32'h1000_FFFE, 0, 1'b1, 1'b0, 1'b0, 0);
        // Two wait states then three stall cycles: 8 cycles total.
        do_inst("waitstall", 32'h0000_0014, 32'h0022_1820, 2, 1'b0, 1'b0, 1'b0, 3);
        // Jump wins over taken branch: {0, 0x40, 00} = 0x100.
        do_inst("jmp_pri", 32'h0000_0018, 32'h0800_0040, 0, 1'b1, 1'b1, 1'b1, 0);
        // Branch with offset -0x45 words from 0x100: 0x104 - 0x114 wraps to 0xFFFF_FFF0.
        do_inst("beq_neg", 32'h0000_0100, 32'h1000_FFBB, 0, 1'b1, 1'b0, 1'b1, 0);
        // Jump in the upper region keeps nibble F: 0xF000_0100.
        do_inst("jmp_hi", 32'hFFFF_FFF0, 32'h0800_0040, 0, 1'b1, 1'b1, 1'b1, 0);
        // Jump to the last word of the address space.
        do_inst("jmp_top", 32'hF000_0100, 32'h0BFF_FFFF, 0, 1'b0, 1'b1, 1'b0, 0);
        // Sequential from 0xFFFF_FFFC wraps to 0.
        do_inst("wrap", 32'hFFFF_FFFC, 32'h0022_1820, 0, 1'b0, 1'b0, 1'b0, 0);

        // Reset mid-FETCH at address 0 with the wrap instruction still held.
        check("mid_state", {30'd0, state_out}, 32'd1);
        check("mid_addr", imem_addr, 32'h0);
        check("mid_inst_before", inst_out, 32'h0022_1820);
        imem_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst_state", {30'd0, state_out}, 32'd0);
        check("arst_pc", pc_out, 32'h0);
        check("arst_inst", inst_out, 32'h0);
        check("arst_req", {31'd0, imem_req}, 32'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        check("arst_late_inst", inst_out, 32'h0);
        check("arst_hold_state", {30'd0, state_out}, 32'd0);
        imem_ready = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_state", {30'd0, state_out}, 32'd1);
        check("post_rst_inst", inst_out, 32'h0);
        do_inst("post_rst", 32'h0000_0000, 32'h8C01_0004, 1, 1'b0, 1'b0, 1'b0, 0);
        check("final_addr", imem_addr, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
